// File: rtl/bsram_pkg.sv
// Shared constants and state encoding for the BSRAM program/data loader.
package bsram_pkg;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 8;
  localparam int LEN_W       = 14;
  localparam int BSRAM_BYTES = 8192;

  // Default program origin the CPU starts executing from.
  localparam logic [ADDR_W-1:0] PROG_BASE = 13'h0200;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } loader_state_t;

endpackage

// File: rtl/bsram_loader.sv
// Streams a byte sequence into the BSRAM write port (cea/ada/din) while
// holding the CPU in reset; releases the CPU after a complete load.
module bsram_loader #(
  parameter int ADDR_W = bsram_pkg::ADDR_W,
  parameter int DATA_W = bsram_pkg::DATA_W,
  parameter int LEN_W  = bsram_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cea,
  output logic [ADDR_W-1:0] ada,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n,
  output logic [DATA_W-1:0] checksum
);

  import bsram_pkg::*;

  // Largest legal load: the whole SRAM.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              cea_q, cea_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  logic [LEN_W-1:0]  len_sat_s;
  logic [LEN_W-1:0]  count_inc_s;
  logic              in_ready_s;
  logic              accept_s;

  // Saturate the requested length, advance the count and decode handshake.
  always_comb begin
    len_sat_s   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    count_inc_s = count_q + LEN_W'(1);
    in_ready_s  = (state_q == LOAD);
    accept_s    = in_valid && in_ready_s;
  end

  // Next-state and datapath updates; write strobe and done default low.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    cea_d       = 1'b0;
    ada_d       = ada_q;
    din_d       = din_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cpu_rst_n_d = cpu_rst_n_q;
    checksum_d  = checksum_q;

    case (state_q)
      IDLE: begin
        // start beats a simultaneous abort because abort is not examined here.
        if (start) begin
          base_d      = load_base;
          len_d       = len_sat_s;
          count_d     = {LEN_W{1'b0}};
          checksum_d  = {DATA_W{1'b0}};
          cpu_rst_n_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (len_sat_s == {LEN_W{1'b0}}) ? FINISH : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          // A byte handshaken in the abort cycle is dropped, not written.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (accept_s) begin
          cea_d      = 1'b1;
          ada_d      = base_q + count_q[ADDR_W-1:0];
          din_d      = in_data;
          checksum_d = checksum_q + in_data;
          count_d    = count_inc_s;
          state_d    = (count_inc_s == len_q) ? FINISH : LOAD;
        end else begin
          state_d = LOAD;
        end
      end
      FINISH: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cpu_rst_n_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= {ADDR_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      count_q     <= {LEN_W{1'b0}};
      cea_q       <= 1'b0;
      ada_q       <= {ADDR_W{1'b0}};
      din_q       <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      checksum_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      cea_q       <= cea_d;
      ada_q       <= ada_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      checksum_q  <= checksum_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign cea       = cea_q;
  assign ada       = ada_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_bsram_loader.sv
// Self-checking bench for bsram_loader: table-driven loads plus hand-written
// abort / mid-load start / mid-load reset sequences, with a write scoreboard.
module tb_bsram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [12:0] load_base;
  logic [13:0] load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cea;
  logic [12:0] ada;
  logic [7:0]  din;
  logic        busy;
  logic        done;
  logic        cpu_rst_n;
  logic [7:0]  checksum;

  int checks;
  int errors;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [12:0] base;
    logic [13:0] len;
    bit          gap;
    bit          mid_start;
    logic [7:0]  seed;
    logic [7:0]  stepv;
    logic [7:0]  exp_sum;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];

  bsram_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .load_base (load_base),
    .load_len  (load_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cea       (cea),
    .ada       (ada),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .cpu_rst_n (cpu_rst_n),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock; sample at the falling edge and score any BSRAM write.
  task automatic step();
    wr_t w;
    @(posedge clk);
    @(negedge clk);
    if (cea === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cea", {19'd0, ada}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("ada", {19'd0, ada}, {19'd0, w.a});
        check("din", {24'd0, din}, {24'd0, w.d});
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cea"},       {31'd0, cea},       32'd0);
    check({tag, "_ada"},       {19'd0, ada},       32'd0);
    check({tag, "_din"},       {24'd0, din},       32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check({tag, "_checksum"},  {24'd0, checksum},  32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
  endtask

  task automatic run_load(input vec_t v);
    int         n;
    logic [7:0] b;
    wr_t        w;
    n = (v.len > 14'd8192) ? 8192 : int'(v.len);
    load_base = v.base;
    load_len  = v.len;
    start     = 1'b1;
    step();
    start     = 1'b0;
    load_base = 13'h0000;
    load_len  = 14'd0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("cpu_rst_low_load", {31'd0, cpu_rst_n}, 32'd0);
    check("in_ready_after_start", {31'd0, in_ready}, (n > 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) begin
      if (v.gap && i > 0) begin
        in_valid = 1'b0;
        step();
      end
      b        = v.seed + 8'(i) * v.stepv;
      in_valid = 1'b1;
      in_data  = b;
      w.a      = v.base + 13'(i);
      w.d      = b;
      exp_q.push_back(w);
      if (v.mid_start && i == 1) begin
        start     = 1'b1;
        load_base = 13'h1234;
        load_len  = 14'd1;
      end
      step();
      in_valid  = 1'b0;
      start     = 1'b0;
      load_base = 13'h0000;
      load_len  = 14'd0;
    end
    check("in_ready_finish", {31'd0, in_ready}, 32'd0);
    check("done_early", {31'd0, done}, 32'd0);
    check("busy_finish", {31'd0, busy}, 32'd1);
    if (v.mid_start) start = 1'b1;
    step();
    start = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("cpu_rst_release", {31'd0, cpu_rst_n}, 32'd1);
    check("checksum", {24'd0, checksum}, {24'd0, v.exp_sum});
    check("writes_outstanding", exp_q.size(), 32'd0);
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("cpu_rst_held_high", {31'd0, cpu_rst_n}, 32'd1);
    check("checksum_hold", {24'd0, checksum}, {24'd0, v.exp_sum});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    load_base = 13'h0000;
    load_len  = 14'd0;
    in_valid  = 1'b0;
    in_data   = 8'h00;

    //                base      len       gap   mid   seed   step   sum
    vecs[0] = '{13'h0200, 14'd1,    1'b0, 1'b0, 8'h06, 8'h00, 8'h06};
    vecs[1] = '{13'h1FFE, 14'd4,    1'b1, 1'b0, 8'h11, 8'h11, 8'hAA};
    vecs[2] = '{13'h0100, 14'd0,    1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{13'h00A5, 14'd5,    1'b0, 1'b1, 8'hF0, 8'h07, 8'hF6};
    vecs[4] = '{13'h1F00, 14'd9000, 1'b0, 1'b0, 8'h05, 8'h03, 8'h00};
    vecs[5] = '{13'h0000, 14'd0,    1'b0, 1'b1, 8'h00, 8'h00, 8'h00};

    // Reset state, during and after reset.
    #5;
    check_reset_values("in_reset");
    step();
    rst_n = 1'b1;
    step();
    check_reset_values("after_reset");

    // Table-driven loads.
    for (int k = 0; k < 6; k++) begin
      run_load(vecs[k]);
    end

    // abort in IDLE: no effect.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);
    check("idle_abort_done", {31'd0, done}, 32'd0);

    // start+abort together in IDLE: start wins; abort after 3 accepts.
    load_base = 13'h0200;
    load_len  = 14'd8;
    start     = 1'b1;
    abort     = 1'b1;
    step();
    start     = 1'b0;
    abort     = 1'b0;
    check("start_wins_busy", {31'd0, busy}, 32'd1);
    check("start_wins_ready", {31'd0, in_ready}, 32'd1);
    check("start_wins_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wr_t w;
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      w.a      = 13'h0200 + 13'(i);
      w.d      = in_data;
      exp_q.push_back(w);
      step();
    end
    in_data = 8'h7E;
    abort   = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cea", {31'd0, cea}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd0);
    check("abort_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    check("abort_writes", exp_q.size(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    check("abort_cpu_rst_hold", {31'd0, cpu_rst_n}, 32'd0);
    run_load('{13'h0300, 14'd2, 1'b0, 1'b0, 8'h80, 8'h01, 8'h01});

    // Asynchronous reset in the middle of a load.
    load_base = 13'h0500;
    load_len  = 14'd6;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      w.a      = 13'h0500 + 13'(i);
      w.d      = in_data;
      exp_q.push_back(w);
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    check("reset_writes", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset_values("post_reset");
    run_load(vecs[1]);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
